// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: shared FSM state and requester-id types for mux_arbiter
package mux_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;
    localparam int HOLD_W = 8;
endpackage

// File: rtl/mux_arbiter_mux.sv
// mux_arbiter_mux: 2:1 datapath mux; ports a, b, sel (0=a, 1=b) -> y
module mux_arbiter_mux #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester arbiter driving a registered 2:1 data mux
// ports: clk, rst (sync, active-high), req_a/req_b, a/b data in;
//        gnt_a/gnt_b, sel, y, y_valid all registered, one-cycle latency
// MUX_ARBITER_TIMEOUT_EN enables preemption after MAX_HOLD grant cycles
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);
    state_t            state, nxt;
    req_id_t           last;
    logic              timeout;
    logic [WIDTH-1:0]  mux_y;
`ifdef MUX_ARBITER_TIMEOUT_EN
    logic [HOLD_W-1:0] cnt;
    assign timeout = cnt == HOLD_W'(MAX_HOLD - 1);
`else
    assign timeout = 1'b0;
`endif
    // owner keeps the grant unless it drops its request or times out against a waiting peer
    always_comb
        nxt = state == IDLE  ? ((req_a && req_b) ? (last == REQ_A ? GNT_B : GNT_A) :
                                req_a ? GNT_A : req_b ? GNT_B : IDLE) :
              state == GNT_A ? ((req_a && !(timeout && req_b)) ? GNT_A : req_b ? GNT_B : IDLE) :
                               ((req_b && !(timeout && req_a)) ? GNT_B : req_a ? GNT_A : IDLE);
    mux_arbiter_mux #(.WIDTH(WIDTH)) u_mux (
        .a  (a),
        .b  (b),
        .sel(nxt == GNT_B),
        .y  (mux_y)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            sel     <= 1'b0;
            y       <= '0;
            y_valid <= 1'b0;
            last    <= REQ_B;
`ifdef MUX_ARBITER_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            state   <= nxt;
            gnt_a   <= nxt == GNT_A;
            gnt_b   <= nxt == GNT_B;
            y_valid <= nxt != IDLE;
            if (nxt != IDLE) begin
                sel  <= nxt == GNT_B;
                y    <= mux_y;
                last <= req_id_t'(nxt == GNT_B);
            end
`ifdef MUX_ARBITER_TIMEOUT_EN
            cnt <= nxt != state ? '0 :
                   (nxt != IDLE && !timeout) ? cnt + 1'b1 : cnt;
`endif
        end
    end
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed and random checks of mux_arbiter against a behavioural model
module tb_mux_arbiter;
`ifdef MUX_ARBITER_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif
    localparam int MAXH = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       gnt_a, gnt_b, sel, y_valid;
    logic [7:0] y;
    int checks = 0, failures = 0;
    int m_own = 0, m_last = 2, m_held = 0;
    logic [7:0] m_y = 8'h00;
    logic       m_sel = 1'b0;
    mux_arbiter #(.WIDTH(8), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .y(y), .y_valid(y_valid)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // owner: 0 none, 1 A, 2 B; held counts cycles the owner has had the grant so far
    task automatic model_edge();
        int nown, mine, other;
        if (rst) begin
            m_own = 0; m_last = 2; m_held = 0; m_y = 8'h00; m_sel = 1'b0;
            return;
        end
        if (m_own == 0)
            nown = (req_a && req_b) ? 3 - m_last : req_a ? 1 : req_b ? 2 : 0;
        else begin
            mine  = m_own == 1 ? int'(req_a) : int'(req_b);
            other = m_own == 1 ? int'(req_b) : int'(req_a);
            if (mine != 0 && !(TO && m_held >= MAXH && other != 0)) nown = m_own;
            else nown = other != 0 ? 3 - m_own : 0;
        end
        m_held = nown == 0 ? 0 : nown == m_own ? m_held + 1 : 1;
        if (nown != 0) begin
            m_last = nown;
            m_y    = nown == 1 ? a : b;
            m_sel  = nown == 2;
        end
        m_own = nown;
    endtask
    task automatic step(input logic r, input logic ra, input logic rb, input logic [7:0] av, input logic [7:0] bv);
        rst = r; req_a = ra; req_b = rb; a = av; b = bv;
        @(posedge clk);
        model_edge();
        #1;
        chk("gnt_a", 32'(gnt_a), 32'(m_own == 1));
        chk("gnt_b", 32'(gnt_b), 32'(m_own == 2));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("y", 32'(y), 32'(m_y));
        chk("y_valid", 32'(y_valid), 32'(m_own != 0));
        chk("excl", 32'(gnt_a & gnt_b), 32'd0);
    endtask
    initial begin
        int n;
        bit run;
        @(posedge clk);
        #1;
        step(1, 1, 1, 8'h11, 8'h22);
        step(1, 1, 1, 8'h11, 8'h22);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        step(0, 1, 1, 8'h33, 8'h44);
        chk("first_gnt_a", 32'(gnt_a), 32'd1);
        step(0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h5A, 8'h00);
        chk("hold_a_y", 32'(y), 32'h5A);
        step(0, 0, 0, 8'h00, 8'h00);
        chk("idle_y_hold", 32'(y), 32'h5A);
        step(0, 1, 1, 8'h01, 8'hB2);
        chk("tie_gnt_b", 32'(gnt_b), 32'd1);
        step(0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'hA1, 8'hB1);
        step(0, 1, 0, 8'hA2, 8'hB2);
        step(0, 0, 1, 8'hA3, 8'hB3);
        chk("handover_y", 32'(y), 32'hB3);
        step(0, 0, 0, 8'h00, 8'h00);
        n = 0; run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 8'(i), 8'(i + 100));
            if (run && gnt_a) n++;
            else run = 1'b0;
        end
        chk("hold_len", 32'(n), TO ? 32'd4 : 32'd20);
        step(0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, 8'hC0 + 8'(i));
        step(1, 1, 1, 8'h77, 8'h88);
        chk("rst_mid_grant", 32'(gnt_b), 32'd0);
        step(0, 1, 1, 8'h99, 8'hAA);
        chk("post_rst_tie_a", 32'(gnt_a), 32'd1);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 31) == 0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
